// File: rtl/sine_lut_rr_scheduler_pkg.sv
// Shared definitions for the sine/cos LUT round-robin scheduler and the
// quarter-wave LUT pipeline it feeds. Keeping LUT_LATENCY_DEF here lets the
// scheduler's tag pipeline and the LUT pipeline agree on depth.
// A tag is laid out as {valid, id}; SINE_LUT_SCHED_TAG_W gives its width.

`define SINE_LUT_SCHED_TAG_W(id_w) (1 + (id_w))

package sine_lut_rr_scheduler_pkg;

  localparam int I_WIDTH_DEF     = 13;
  localparam int O_WIDTH_DEF     = 12;
  localparam int LUT_LATENCY_DEF = 3;

endpackage

// File: rtl/sine_lut_rr_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: searches upward from ptr+1 (wrapping)
// and grants the first active request. The pointer register lives in the
// parent so this block stays stateless.

module rr_arbiter
  import sine_lut_rr_scheduler_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ID_WIDTH = 2
) (
  input  logic [N_REQ-1:0]    req,
  input  logic [ID_WIDTH-1:0] ptr,
  input  logic                en,
  output logic [N_REQ-1:0]    grant,
  output logic [ID_WIDTH-1:0] grant_id
);

  logic found;
  int   idx;

  // Priority search starting just after the last winner.
  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred and later lines see earlier ones.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    idx      = 0;
    for (int k = 1; k <= N_REQ; k++) begin
      idx = (int'(ptr) + k) % N_REQ;
      if (en && !found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_id   = ID_WIDTH'(idx);
      end
    end
  end

endmodule

// File: rtl/sine_lut_rr_scheduler.sv
// Time-shares one quarter-wave sine/cos LUT pipeline among N_REQ phase
// requesters. Accepted phases are tagged with their requester ID; the tag
// rides a LUT_LATENCY-deep shift register frozen together with the LUT by
// i_en, so responses come out aligned with the LUT data.
// Optional build macro SINE_LUT_SCHED_STATS_EN adds a saturating 16-bit
// contention counter (o_wait_cnt) with a synchronous clear (i_stats_clr).

module sine_lut_rr_scheduler
  import sine_lut_rr_scheduler_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int ID_WIDTH    = 2,
  parameter int I_WIDTH     = I_WIDTH_DEF,
  parameter int O_WIDTH     = O_WIDTH_DEF,
  parameter int LUT_LATENCY = LUT_LATENCY_DEF
) (
  input  logic                      i_clk,
  input  logic                      i_rst,
  input  logic                      i_en,
  input  logic [N_REQ-1:0]          i_req_valid,
  input  logic [N_REQ*I_WIDTH-1:0]  i_req_phase,
  output logic [N_REQ-1:0]          o_req_ready,
  output logic                      o_lut_en,
  output logic [I_WIDTH-1:0]        o_lut_phase,
  input  logic signed [O_WIDTH-1:0] i_lut_sin,
  input  logic signed [O_WIDTH-1:0] i_lut_cos,
  output logic                      o_rsp_valid,
  output logic [ID_WIDTH-1:0]       o_rsp_id,
  output logic signed [O_WIDTH-1:0] o_rsp_sin,
  output logic signed [O_WIDTH-1:0] o_rsp_cos,
  output logic                      o_busy
`ifdef SINE_LUT_SCHED_STATS_EN
  ,
  output logic [15:0]               o_wait_cnt,
  input  logic                      i_stats_clr
`endif
);

  typedef struct packed {
    logic                valid;
    logic [ID_WIDTH-1:0] id;
  } tag_t;

  logic [ID_WIDTH-1:0] ptr_q;
  logic [I_WIDTH-1:0]  phase_q;
  tag_t                tag_q [LUT_LATENCY];

  logic [N_REQ-1:0]    grant;
  logic [ID_WIDTH-1:0] grant_id;
  logic                handshake;
  logic [I_WIDTH-1:0]  grant_phase;
  logic [`SINE_LUT_SCHED_TAG_W(ID_WIDTH)-1:0] last_tag;
  logic                busy;

  rr_arbiter #(
    .N_REQ    (N_REQ),
    .ID_WIDTH (ID_WIDTH)
  ) u_rr_arbiter (
    .req      (i_req_valid),
    .ptr      (ptr_q),
    .en       (i_en),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // The arbiter only grants valid requesters while enabled, so a grant is a handshake.
  assign handshake   = |grant;
  assign o_req_ready = grant;
  assign grant_phase = i_req_phase[int'(grant_id)*I_WIDTH +: I_WIDTH];

  // The winning phase goes to the LUT in the same cycle; otherwise the last one holds.
  assign o_lut_phase = handshake ? grant_phase : phase_q;
  assign o_lut_en    = i_en;

  // Pointer and held phase advance only on a handshake.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ptr_q   <= ID_WIDTH'(N_REQ - 1);
      phase_q <= '0;
    end else if (handshake) begin
      ptr_q   <= grant_id;
      phase_q <= grant_phase;
    end
  end

  // Tag shift register, stepped in lockstep with the enabled LUT pipeline.
  // NOTE: only the tags are reset; in-flight LUT data is left alone because
  // a cleared tag already marks it as garbage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < LUT_LATENCY; i++) tag_q[i] <= '0;
    end else if (i_en) begin
      tag_q[0] <= '{valid: handshake, id: grant_id};
      for (int i = 1; i < LUT_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  // Busy while any tag in the pipeline is valid.
  always_comb begin
    busy = 1'b0;
    for (int i = 0; i < LUT_LATENCY; i++) busy = busy | tag_q[i].valid;
  end

  assign o_busy      = busy;
  assign last_tag    = tag_q[LUT_LATENCY-1];
  assign o_rsp_valid = last_tag[ID_WIDTH] & i_en;
  assign o_rsp_id    = last_tag[ID_WIDTH-1:0] & {ID_WIDTH{i_en}};
  assign o_rsp_sin   = i_lut_sin;
  assign o_rsp_cos   = i_lut_cos;

`ifdef SINE_LUT_SCHED_STATS_EN
  logic [15:0] wait_q;
  logic        waiting;

  // Someone asked but was not served this enabled cycle.
  assign waiting = i_en & (|(i_req_valid & ~grant));

  // Saturating contention counter; clear has priority over increment.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wait_q <= '0;
    end else if (i_stats_clr) begin
      wait_q <= '0;
    end else if (waiting && (wait_q != 16'hFFFF)) begin
      wait_q <= wait_q + 16'd1;
    end
  end

  assign o_wait_cnt = wait_q;
`endif

endmodule

// File: tb/tb_sine_lut_rr_scheduler.sv
// Self-checking bench for sine_lut_rr_scheduler: a behavioural LUT, a
// transaction-level scoreboard keyed by enabled-cycle count, directed
// scenarios and a randomized soak.

module tb_sine_lut_rr_scheduler;
  import sine_lut_rr_scheduler_pkg::*;

  localparam int N   = 4;
  localparam int IDW = 2;
  localparam int IW  = I_WIDTH_DEF;
  localparam int OW  = O_WIDTH_DEF;
  localparam int L   = LUT_LATENCY_DEF;

  logic                 i_clk = 1'b0;
  logic                 i_rst;
  logic                 i_en;
  logic [N-1:0]         i_req_valid;
  logic [N*IW-1:0]      i_req_phase;
  logic [N-1:0]         o_req_ready;
  logic                 o_lut_en;
  logic [IW-1:0]        o_lut_phase;
  logic signed [OW-1:0] i_lut_sin;
  logic signed [OW-1:0] i_lut_cos;
  logic                 o_rsp_valid;
  logic [IDW-1:0]       o_rsp_id;
  logic signed [OW-1:0] o_rsp_sin;
  logic signed [OW-1:0] o_rsp_cos;
  logic                 o_busy;
  logic                 i_stats_clr;
`ifdef SINE_LUT_SCHED_STATS_EN
  logic [15:0]          o_wait_cnt;
`endif

  sine_lut_rr_scheduler #(
    .N_REQ(N), .ID_WIDTH(IDW), .I_WIDTH(IW), .O_WIDTH(OW), .LUT_LATENCY(L)
  ) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_en        (i_en),
    .i_req_valid (i_req_valid),
    .i_req_phase (i_req_phase),
    .o_req_ready (o_req_ready),
    .o_lut_en    (o_lut_en),
    .o_lut_phase (o_lut_phase),
    .i_lut_sin   (i_lut_sin),
    .i_lut_cos   (i_lut_cos),
    .o_rsp_valid (o_rsp_valid),
    .o_rsp_id    (o_rsp_id),
    .o_rsp_sin   (o_rsp_sin),
    .o_rsp_cos   (o_rsp_cos),
    .o_busy      (o_busy)
`ifdef SINE_LUT_SCHED_STATS_EN
    ,
    .o_wait_cnt  (o_wait_cnt),
    .i_stats_clr (i_stats_clr)
`endif
  );

  always #5 i_clk = ~i_clk;

  // ---------------- behavioural LUT ----------------
  function automatic logic signed [OW-1:0] round_fs(input real r);
    real s;
    s = r * 2047.0;
    if (s >= 0.0) return OW'($rtoi(s + 0.5));
    else          return -OW'($rtoi(-s + 0.5));
  endfunction

  function automatic real ang(input logic [IW-1:0] p);
    return 2.0 * 3.14159265358979 * real'(p) / real'(1 << IW);
  endfunction

  function automatic logic signed [OW-1:0] sin_f(input logic [IW-1:0] p);
    return round_fs($sin(ang(p)));
  endfunction

  function automatic logic signed [OW-1:0] cos_f(input logic [IW-1:0] p);
    return round_fs($cos(ang(p)));
  endfunction

  logic [IW-1:0] lut_pipe [L];

  always @(posedge i_clk) begin
    if (o_lut_en) begin
      lut_pipe[0] <= o_lut_phase;
      for (int i = 1; i < L; i++) lut_pipe[i] <= lut_pipe[i-1];
    end
  end

  always_comb begin
    i_lut_sin = sin_f(lut_pipe[L-1]);
    i_lut_cos = cos_f(lut_pipe[L-1]);
  end

  // ---------------- scoreboard / reference ----------------
  typedef struct {
    int            id;
    logic [IW-1:0] ph;
  } exp_t;

  exp_t          resp_at [longint];   // expected response, keyed by enabled-cycle index
  longint        ecnt;                // enabled clock edges seen so far
  int            m_ptr;
  logic [IW-1:0] m_phase;
  int            m_wait;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [N-1:0]  last_ready;
  logic          last_rsp_valid;
  logic [IDW-1:0] last_rsp_id;
  logic signed [OW-1:0] last_rsp_sin, last_rsp_cos;
  int            rsp_cnt [N];
  logic [15:0]   last_wait;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [N*IW-1:0] rand_ph();
    logic [N*IW-1:0] r;
    for (int i = 0; i < N; i++) r[i*IW +: IW] = IW'($urandom);
    return r;
  endfunction

  task automatic model_reset();
    resp_at.delete();
    m_ptr   = N - 1;
    m_phase = '0;
    m_wait  = 0;
  endtask

  // One clock: drive on the falling edge, check just after, then advance the model.
  task automatic step(input logic en, input logic [N-1:0] v,
                      input logic [N*IW-1:0] ph, input logic clr);
    int           g;
    logic [N-1:0] g_oh;
    logic         exp_v;
    logic         exp_busy;
    exp_t         e;
    @(negedge i_clk);
    i_en        = en;
    i_req_valid = v;
    i_req_phase = ph;
    i_stats_clr = clr;
    #1;
    g = -1;
    if (en) begin
      for (int k = 1; k <= N; k++) begin
        int idx;
        idx = (m_ptr + k) % N;
        if (g < 0 && v[idx]) g = idx;
      end
    end
    g_oh = (g >= 0) ? (N'(1) << g) : '0;
    check("ready", 64'(o_req_ready), 64'(g_oh));
    check("lut_en", 64'(o_lut_en), 64'(en));
    check("lut_phase", 64'(o_lut_phase), 64'((g >= 0) ? ph[g*IW +: IW] : m_phase));
    exp_v = en && resp_at.exists(ecnt);
    check("rsp_valid", 64'(o_rsp_valid), 64'(exp_v));
    if (exp_v) begin
      e = resp_at[ecnt];
      check("rsp_id", 64'(o_rsp_id), 64'(e.id));
      check("rsp_sin", 64'(o_rsp_sin), 64'(sin_f(e.ph)));
      check("rsp_cos", 64'(o_rsp_cos), 64'(cos_f(e.ph)));
    end
    exp_busy = 1'b0;
    for (longint k = ecnt; k < ecnt + L; k++) if (resp_at.exists(k)) exp_busy = 1'b1;
    check("busy", 64'(o_busy), 64'(exp_busy));
`ifdef SINE_LUT_SCHED_STATS_EN
    check("wait_cnt", 64'(o_wait_cnt), 64'(m_wait));
    last_wait = o_wait_cnt;
`endif
    last_ready     = o_req_ready;
    last_rsp_valid = o_rsp_valid;
    last_rsp_id    = o_rsp_id;
    last_rsp_sin   = o_rsp_sin;
    last_rsp_cos   = o_rsp_cos;
    if (o_rsp_valid) rsp_cnt[o_rsp_id]++;
    if (en) begin
      if (g >= 0) begin
        resp_at[ecnt + L] = '{id: g, ph: ph[g*IW +: IW]};
        m_ptr   = g;
        m_phase = ph[g*IW +: IW];
      end
      if (exp_v) resp_at.delete(ecnt);
      ecnt++;
    end
    if (clr) m_wait = 0;
    else if (en && ((v & ~g_oh) != '0) && m_wait < 65535) m_wait++;
    @(posedge i_clk);
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_rst = 1'b1;
    i_en = 1'b0; i_req_valid = '0; i_stats_clr = 1'b0;
    repeat (2) @(negedge i_clk);
    i_rst = 1'b0;
    model_reset();
  endtask

  initial begin
    logic [N*IW-1:0] ph;
    logic [N-1:0]    ready_or;
    int              base [N];
    int              cnt_before;

    i_rst = 1'b1; i_en = 1'b0; i_req_valid = '0; i_req_phase = '0; i_stats_clr = 1'b0;
    ecnt = 0;
    for (int i = 0; i < N; i++) rsp_cnt[i] = 0;
    model_reset();
    #1;
    check("reset_rsp_valid", 64'(o_rsp_valid), 64'd0);
    check("reset_busy", 64'(o_busy), 64'd0);
    check("reset_lut_phase", 64'(o_lut_phase), 64'd0);
    check("reset_rsp_id", 64'(o_rsp_id), 64'd0);
    do_reset();

    // Single request from requester 2 at a quarter turn.
    ph = rand_ph();
    ph[2*IW +: IW] = 13'h0800;
    step(1'b1, 4'b0100, ph, 1'b0);
    check("single_ready", 64'(last_ready), 64'(4'b0100));
    step(1'b1, '0, rand_ph(), 1'b0);
    step(1'b1, '0, rand_ph(), 1'b0);
    check("single_early", 64'(last_rsp_valid), 64'd0);
    step(1'b1, '0, rand_ph(), 1'b0);
    check("single_valid", 64'(last_rsp_valid), 64'd1);
    check("single_id", 64'(last_rsp_id), 64'd2);
    check("single_sin", 64'(last_rsp_sin), 64'(12'sd2047));
    check("single_cos", 64'(last_rsp_cos), 64'(12'sd0));

    // All requesters contending: strict 0,1,2,3 rotation and 4 responses each.
    do_reset();
    for (int i = 0; i < N; i++) base[i] = rsp_cnt[i];
    for (int c = 0; c < 16; c++) begin
      step(1'b1, 4'b1111, rand_ph(), 1'b0);
      check("rot_grant", 64'(last_ready), 64'(4'b0001 << (c % N)));
    end
    repeat (L) step(1'b1, '0, rand_ph(), 1'b0);
    for (int i = 0; i < N; i++) check("rot_count", 64'(rsp_cnt[i] - base[i]), 64'd4);

    // Pointer wrap and skip.
    step(1'b1, 4'b1000, rand_ph(), 1'b0);
    check("wrap_setup", 64'(last_ready), 64'(4'b1000));
    step(1'b1, 4'b1010, rand_ph(), 1'b0);
    check("wrap_grant1", 64'(last_ready), 64'(4'b0010));
    step(1'b1, 4'b1010, rand_ph(), 1'b0);
    check("wrap_grant3", 64'(last_ready), 64'(4'b1000));
    repeat (L) step(1'b1, '0, rand_ph(), 1'b0);

    // Enable low with two tags in flight, one of them due during the stall.
    for (int i = 0; i < N; i++) base[i] = rsp_cnt[i];
    step(1'b1, 4'b0001, rand_ph(), 1'b0);
    step(1'b1, 4'b0010, rand_ph(), 1'b0);
    step(1'b1, '0, rand_ph(), 1'b0);
    ready_or = '0;
    cnt_before = rsp_cnt[0] + rsp_cnt[1];
    for (int c = 0; c < 5; c++) begin
      step(1'b0, 4'b1111, rand_ph(), 1'b0);
      ready_or |= last_ready;
    end
    check("stall_ready", 64'(ready_or), 64'd0);
    check("stall_rsp", 64'(rsp_cnt[0] + rsp_cnt[1]), 64'(cnt_before));
    step(1'b1, '0, rand_ph(), 1'b0);
    check("resume_id0", 64'(last_rsp_id), 64'd0);
    step(1'b1, '0, rand_ph(), 1'b0);
    check("resume_id1", 64'(last_rsp_id), 64'd1);
    check("resume_cnt0", 64'(rsp_cnt[0] - base[0]), 64'd1);
    check("resume_cnt1", 64'(rsp_cnt[1] - base[1]), 64'd1);

    // Asynchronous reset with three tags in flight.
    repeat (3) step(1'b1, 4'b1111, rand_ph(), 1'b0);
    #2;
    check("pre_rst_valid", 64'(o_rsp_valid), 64'd1);
    i_rst = 1'b1;
    #1;
    check("rst_valid", 64'(o_rsp_valid), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    model_reset();
    @(posedge i_clk);
    #2 i_rst = 1'b0;
    for (int c = 0; c < L; c++) begin
      step(1'b1, '0, rand_ph(), 1'b0);
      check("post_rst_valid", 64'(last_rsp_valid), 64'd0);
    end
    step(1'b1, 4'b1111, rand_ph(), 1'b0);
    check("post_rst_grant", 64'(last_ready), 64'(4'b0001));

    // Randomized soak.
    for (int c = 0; c < 400; c++) begin
      step(($urandom_range(7) != 0), N'($urandom), rand_ph(), ($urandom_range(31) == 0));
    end

`ifdef SINE_LUT_SCHED_STATS_EN
    do_reset();
    repeat (10) step(1'b1, 4'b1111, rand_ph(), 1'b0);
    step(1'b1, '0, rand_ph(), 1'b0);
    check("stats_ten", 64'(last_wait), 64'd10);
    step(1'b1, 4'b1111, rand_ph(), 1'b1);
    step(1'b1, '0, rand_ph(), 1'b0);
    check("stats_clr", 64'(last_wait), 64'd0);
    for (int c = 0; c < 65540; c++) step(1'b1, 4'b1111, rand_ph(), 1'b0);
    step(1'b1, 4'b1111, rand_ph(), 1'b0);
    check("stats_sat", 64'(last_wait), 64'hFFFF);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sine_lut_rr_scheduler.md
Name: sine_lut_rr_scheduler

Overview:
- Time-shares one single-channel quarter-wave sine/cos LUT pipeline among N_REQ phase requesters.
- Uses round-robin arbitration with a valid/ready handshake per requester.
- Tags each accepted phase with its requester ID and delivers sin/cos results with that ID after a fixed pipeline latency.
- Sits between per-channel phase accumulators (NCOs) and the shared LUT + quarterwave-logic pipeline, so channels that do not need one sample every clock can avoid separate ROM ports.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- ID_WIDTH, 2, requester ID width; must satisfy 2**ID_WIDTH >= N_REQ.
- I_WIDTH, 13, phase width.
- O_WIDTH, 12, signed sin/cos width.
- LUT_LATENCY, 3, clocks from o_lut_phase (while o_lut_en=1) to valid i_lut_sin/i_lut_cos; must be >= 1.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  asynchronous, active-high reset.
- i_en  in  1  global enable; also freezes the LUT pipeline.
- i_req_valid  in  N_REQ  per-requester phase valid.
- i_req_phase  in  N_REQ*I_WIDTH  packed phases; requester n occupies bits [n*I_WIDTH +: I_WIDTH].
- o_req_ready  out  N_REQ  one-hot accept strobe.
- o_lut_en  out  1  LUT pipeline enable.
- o_lut_phase  out  I_WIDTH  phase driven to the LUT.
- i_lut_sin  in  O_WIDTH  signed LUT sine result.
- i_lut_cos  in  O_WIDTH  signed LUT cosine result.
- o_rsp_valid  out  1  response valid, one-cycle pulse per accepted request.
- o_rsp_id  out  ID_WIDTH  requester ID of the response.
- o_rsp_sin  out  O_WIDTH  signed sine result.
- o_rsp_cos  out  O_WIDTH  signed cosine result.
- o_busy  out  1  at least one tag in flight.

Behaviour:
- Reset values: rr pointer = N_REQ-1 (requester 0 wins first); tag pipeline valid bits = 0; o_rsp_valid = 0; o_rsp_id = 0; o_busy = 0; o_lut_phase register = 0.
- o_rsp_sin/o_rsp_cos pass straight through from the LUT and are don't-care while o_rsp_valid = 0.
- Arbitration is combinational within the cycle. Grant goes to the first requester with i_req_valid=1, searching from (pointer+1) mod N_REQ upward and wrapping.
- o_req_ready[g] = i_en & i_req_valid[g] for the granted requester g; all other bits are 0.
  - Ready never asserts without valid.
  - At most one ready bit is high per cycle.
- A handshake occurs when valid & ready. On a handshake:
  - pointer <= g;
  - o_lut_phase is driven combinationally from the granted phase;
  - tag {1, g} is pushed into stage 0 of a LUT_LATENCY-deep shift register.
- No handshake and i_en=1: a bubble tag {0, x} is pushed; o_lut_phase holds its previous value.
- o_lut_en = i_en. When i_en=0:
  - no grants;
  - tag pipeline and pointer frozen;
  - o_rsp_valid forced to 0.
  - Tags resume aligned with the LUT when i_en returns to 1.
- Response: o_rsp_valid / o_rsp_id = last tag stage & i_en. Sin/cos are taken from i_lut_sin/i_lut_cos in the same cycle. Latency from handshake to o_rsp_valid is exactly LUT_LATENCY enabled cycles.
- Responses have no backpressure; the consumer must accept every o_rsp_valid pulse.
- Throughput: one request per enabled clock in aggregate. With all N_REQ requesting continuously, each requester is served exactly once every N_REQ cycles (starvation-free).
- Simultaneous events:
  - A requester that drops valid in the same cycle its grant is computed simply loses the grant; the pointer does not advance.
  - A request and a response for the same ID in one cycle is legal.
- Reset mid-operation:
  - all in-flight tags are discarded and no stale o_rsp_valid is produced;
  - LUT data still in flight is ignored because its tags were cleared.
- o_busy = OR of tag valid bits.

Optional Feature:
- Macro: SINE_LUT_SCHED_STATS_EN.
- Defined:
  - adds output o_wait_cnt, 16 bits, saturating;
  - increments by 1 on every enabled cycle in which some i_req_valid bit is set but not granted (popcount(valid) > handshake count);
  - holds at 16'hFFFF once saturated;
  - cleared by i_rst;
  - also adds input i_stats_clr, which synchronously zeroes the counter. If clear and increment coincide, clear wins.
- Undefined: neither port exists and no counter logic is generated.

Decomposition:
- Shared package/include holds:
  - default widths (I_WIDTH=13, O_WIDTH=12);
  - the tag struct layout {valid, id} and its width macro;
  - LUT_LATENCY default, shared with the quarterwave-logic pipeline so the two cannot drift.
- One natural sub-module: rr_arbiter.
  - Parameter N_REQ.
  - Inputs: request vector, pointer, enable.
  - Outputs: one-hot grant and encoded grant ID.
  - Purely combinational; the pointer register stays in the parent.

Test Plan:
- Reset then single request: valid=4'b0100, phase=13'h0800 → ready[2] same cycle; o_rsp_valid with id=2 exactly 3 clocks later; sin=+full-scale, cos≈0 (LUT model).
- All four requesters valid continuously for 16 cycles → grant order 0,1,2,3,0,…; each ID gets exactly 4 responses, in the same order, each 3 cycles after its grant.
- Pointer wrap and skip: pointer=3, valid=4'b1010 → grant 1; next cycle the same request pattern → grant 3.
- i_en low for 5 cycles with 2 tags in flight → no ready, no o_rsp_valid. After re-enable, the responses emerge after the remaining enabled-cycle count with correct IDs and data.
- Assert i_rst asynchronously with 3 tags in flight → o_rsp_valid=0 immediately and for the following 3 cycles after release. The first post-reset grant goes to requester 0.
- With SINE_LUT_SCHED_STATS_EN: valid=4'b1111 for 10 cycles → o_wait_cnt=10. Pulsing i_stats_clr → 0. Forcing the count to 16'hFFFF then continuing to contend → o_wait_cnt holds 16'hFFFF.
